// File: rtl/sw_stream_scheduler.sv
// Stream scheduler between a query/target front end and a Smith-Waterman scoring array.
// Define SW_SCORE_UNBIAS_EN to add ZERO to the array score (unbiasing) on the result path.
module sw_stream_scheduler #(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 128,
  parameter int ID_WIDTH    = 8,
  parameter int TAG_DEPTH   = 4,
  parameter int ZERO        = 2**(SCORE_WIDTH-1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   q_load,
  input  logic [2*LENGTH-1:0]    q_data,
  input  logic [7:0]             q_len,
  output logic                   q_ready,
  input  logic                   s_valid,
  input  logic [1:0]             s_base,
  input  logic                   s_last,
  input  logic [ID_WIDTH-1:0]    s_id,
  output logic                   s_ready,
  output logic                   arr_en,
  output logic [1:0]             arr_base,
  output logic [2*LENGTH-1:0]    arr_query,
  output logic [7:0]             arr_len,
  input  logic                   arr_vld,
  input  logic [SCORE_WIDTH-1:0] arr_result,
  output logic                   r_valid,
  output logic [SCORE_WIDTH-1:0] r_score,
  output logic [ID_WIDTH-1:0]    r_id,
  input  logic                   r_ready,
  output logic                   busy,
  output logic [1:0]             err
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

`ifdef SW_SCORE_UNBIAS_EN
  localparam bit UNBIAS = 1'b1;
`else
  localparam bit UNBIAS = 1'b0;
`endif
  localparam logic [SCORE_WIDTH-1:0] BIAS = UNBIAS ? SCORE_WIDTH'(ZERO) : '0;

  typedef enum logic [1:0] {NOQ, IDLE, STREAM, GAP} state_t;

  state_t state, state_next;

  logic [ID_WIDTH-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    tag_count;
  logic                tag_empty;
  logic                arr_vld_q;

  logic load_ok, accept, push, vld_edge, pop, result_load;
  logic [SCORE_WIDTH-1:0] score_out;

  assign tag_empty   = (tag_count == '0);
  assign load_ok     = q_load & q_ready;
  assign accept      = s_valid & s_ready;
  assign push        = accept & s_last;
  assign vld_edge    = arr_vld & ~arr_vld_q;
  assign pop         = vld_edge & ~tag_empty;
  // A result is dropped (but its tag still retired) when the output register is stalled.
  assign result_load = pop & (~r_valid | r_ready);
  assign score_out   = arr_result + BIAS;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    q_ready    = 1'b0;
    s_ready    = 1'b0;
    busy       = ~tag_empty | (state == STREAM);

    if ((state == NOQ || state == IDLE) && tag_empty && !r_valid)
      q_ready = 1'b1;
    if ((state == IDLE || state == STREAM) &&
        ((tag_count < CNT_W'(TAG_DEPTH)) || state == STREAM) && !q_load)
      s_ready = 1'b1;

    case (state)
      NOQ:     if (load_ok) state_next = IDLE;
      IDLE:    if (accept)  state_next = s_last ? GAP : STREAM;
      STREAM:  if (accept && s_last) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = NOQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= NOQ;
      arr_query <= '0;
      arr_len   <= '0;
      arr_en    <= 1'b0;
      arr_base  <= '0;
      arr_vld_q <= 1'b0;
    end else begin
      state     <= state_next;
      arr_en    <= accept;
      arr_vld_q <= arr_vld;
      if (accept)  arr_base <= s_base;
      if (load_ok) begin
        arr_query <= q_data;
        arr_len   <= q_len;
      end
    end
  end

  // NOTE: tag storage has no reset; pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= s_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   tag_count <= tag_count + CNT_W'(1);
        2'b01:   tag_count <= tag_count - CNT_W'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_score <= '0;
      r_id    <= '0;
      err     <= '0;
    end else begin
      if (result_load) begin
        r_valid <= 1'b1;
        r_score <= score_out;
        r_id    <= tag_mem[rd_ptr];
      end else if (r_ready) begin
        r_valid <= 1'b0;
      end
      if (pop && r_valid && !r_ready) err[0] <= 1'b1;
      if (vld_edge && tag_empty)      err[1] <= 1'b1;
    end
  end

endmodule

// File: doc/sw_stream_scheduler.md
SW_STREAM_SCHEDULER -- requirements
Module: sw_stream_scheduler

Interface
REQ-001 Parameter SCORE_WIDTH, default 12: score width in bits, matches the scoring array.
REQ-002 Parameter LENGTH, default 128: number of array processing elements, which is also the maximum query length.
REQ-003 Parameter ID_WIDTH, default 8: width of the sequence tag.
REQ-004 Parameter TAG_DEPTH, default 4: maximum number of sequences in flight (power of 2).
REQ-005 Parameter ZERO, default 2**(SCORE_WIDTH-1): biased zero of the array's score.
REQ-006 clk  in  1  sole clock; all logic on the rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 q_load  in  1  load the query; accepted only when q_ready=1.
REQ-009 q_data  in  2*LENGTH  query bitstream; base i is at bits [2i+:2] (T=00, C=01, A=10, G=11).
REQ-010 q_len  in  8  query length, 1..LENGTH.
REQ-011 q_ready  out  1  query may be (re)loaded.
REQ-012 s_valid, s_base[1:0], s_last, s_id[ID_WIDTH-1:0]  in: target base stream; s_last marks the final base; s_id is sampled with s_last.
REQ-013 s_ready  out  1  target base accepted when s_valid&s_ready.
REQ-014 arr_en, arr_base[1:0], arr_query[2*LENGTH-1:0], arr_len[7:0]  out: drive the array's en_in, data_in, query and output_select.
REQ-015 arr_vld, arr_result[SCORE_WIDTH-1:0]  in: array result strobe and biased score.
REQ-016 r_valid, r_score[SCORE_WIDTH-1:0], r_id  out; r_ready  in: result stream.
REQ-017 busy  out  1  high while any sequence is in flight.
REQ-018 err[1:0]  out: sticky flags; bit0 = result overflow, bit1 = orphan result.

Function
REQ-019 The FSM SHALL have the states NOQ, IDLE, STREAM and GAP.
REQ-020 The FSM SHALL move from NOQ to IDLE on q_load.
REQ-021 The FSM SHALL move from IDLE to STREAM on an accepted base with s_last=0.
REQ-022 The FSM SHALL move from IDLE or STREAM to GAP on an accepted base with s_last=1.
REQ-023 The FSM SHALL move from GAP to IDLE unconditionally after exactly one cycle.
REQ-024 q_ready SHALL equal (state in {NOQ, IDLE}) & tag FIFO empty & !r_valid.
REQ-025 On q_load&q_ready, the block SHALL register q_data and q_len onto arr_query and arr_len; both SHALL hold until the next accepted load.
REQ-026 q_load while q_ready=0 SHALL be ignored.
REQ-027 s_ready SHALL equal (state in {IDLE, STREAM}) & (tag count < TAG_DEPTH or state=STREAM) & !q_load.
REQ-028 An accepted base SHALL appear on arr_base with arr_en=1 on the next cycle (1-cycle latency).
REQ-029 When no base is accepted, arr_en SHALL be 0 on the next cycle.
REQ-030 arr_en SHALL be 0 in the cycle driven from GAP, so a one-cycle bubble always separates sequences.
REQ-031 An accepted s_last SHALL push s_id into the tag FIFO.
REQ-032 An arr_vld rising edge SHALL pop the tag FIFO and load {arr_result, tag} into the output register, setting r_valid.
REQ-033 r_valid SHALL clear on r_valid&r_ready unless a new result loads in the same cycle; the new result takes priority and keeps r_valid=1.
REQ-034 An arr_vld edge while r_valid=1 and r_ready=0 SHALL set err[0] and drop the new result; the tag is still popped.
REQ-035 An arr_vld edge with the tag FIFO empty SHALL set err[1] and produce no result.
REQ-036 busy SHALL equal (tag count != 0) | (state=STREAM).
REQ-037 A push and a pop in the same cycle SHALL leave the tag count unchanged; FIFO pointers wrap modulo TAG_DEPTH.
REQ-038 Only NOQ leaves IDLE/STREAM without a query; the block SHALL never reach STREAM from NOQ.

Reset
REQ-039 On rst=0 the block SHALL asynchronously enter NOQ and clear: tag FIFO, r_valid, arr_en, busy, err, arr_base, arr_query, arr_len, r_score, r_id.
REQ-040 On rst=0, s_ready and q_ready SHALL evaluate per REQ-027/REQ-024 (q_ready=1).
REQ-041 A reset during STREAM SHALL discard the partial sequence and all in-flight tags; the array must be reset by the same rst.

Configuration
REQ-042 The macro SW_SCORE_UNBIAS_EN SHALL control score unbiasing.
REQ-043 With SW_SCORE_UNBIAS_EN defined, r_score SHALL equal arr_result+ZERO, truncated to SCORE_WIDTH.
REQ-044 Without SW_SCORE_UNBIAS_EN, r_score SHALL equal arr_result unmodified.

Verification
REQ-045 Load q_len=4, query "ACGT" -> arr_len=4, arr_query[7:0]=8'b00_11_01_10, q_ready=0 while busy.
REQ-046 Stream "GATT" with s_id=5 and s_last on "T" -> arr_en high for 4 cycles then low 1 cycle; arr_base=11,10,00,00; tag 5 pushed.
REQ-047 Send three back-to-back sequences (ids 1,2,3), then pulse arr_vld three times with arr_result=2058,2048,2051 -> r_id=1,2,3 in order; r_score=10,0,3 with SW_SCORE_UNBIAS_EN, 2058,2048,2051 without.
REQ-048 Start TAG_DEPTH=4 sequences with no arr_vld -> s_ready=0 in IDLE; one arr_vld -> s_ready returns to 1.
REQ-049 Hold r_ready=0 and pulse arr_vld twice -> first result held, err=01; pulse arr_vld with the FIFO empty -> err=11.
REQ-050 Assert rst=0 mid-STREAM -> all outputs at reset values within the same cycle; q_ready=1, arr_en=0.
